mul_div_unit: RTL and testbench
===============================

# mul_div_unit

- Iterative RV64M multiply/divide unit for the execute stage.
- Accepts the E-stage M-extension operation and drives `ok`, which the hazard unit consumes as `mult_ok`.
- While `ok` is low the hazard unit stalls F/D/E and bubbles M; the unit holds its result until the E-stage instruction advances.

## Interface
Parameters:
- MUL_CHUNK, 16, multiplier bits retired per cycle; must divide 64 (MUL iterations = 64/MUL_CHUNK).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  E stage holds an M-extension instruction
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- word  in  1  *W variant: use src[31:0], sign-extend the 32-bit result
- src_a  in  64  rs1 operand (forwarded)
- src_b  in  64  rs2 operand (forwarded)
- hold  in  1  E held for a reason other than this unit (`~d_data_ok`); must not depend on `ok`
- flush  in  1  kill the E-stage instruction
- ok  out  1  result available or no operation in progress; reset 1
- result  out  64  valid when `ok`=1 and state is DONE; reset 0

## Operation
States: IDLE, MUL, DIV, DONE. Reset → IDLE, counter 0, result 0.

IDLE:
- `ok` = ~valid (combinational).
- valid=1 → latch operand magnitudes, sign flags, op and word; next state MUL (op[2]=0) or DIV (op[2]=1); counter cleared.
- The latch cycle is itself a busy cycle.

MUL:
- Unsigned shift-add of |a|×|b|, MUL_CHUNK bits of b per cycle, into a 128-bit accumulator.
- Signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU/MUL unsigned-equivalent.
- Final cycle negates the product if the operand signs differ.
- Result selection: MUL/MULW take the low 64 bits (MULW: low 32, sign-extended); MULH* take the high 64 bits.
- After 64/MUL_CHUNK cycles → DONE.

DIV:
- Radix-2 restoring division on magnitudes, one quotient bit per cycle.
- 64 iterations; word ops 32 iterations.
- Finalize on the transition to DONE:
  - negate the quotient when signs differ (signed ops);
  - the remainder takes the dividend's sign;
  - divisor zero → quotient all-ones, remainder = dividend;
  - signed overflow (MIN / −1) → quotient MIN, remainder 0.
- Word ops apply both special cases to the 32-bit values, then sign-extend.

DONE:
- `ok`=1, result stable.
- hold=0 → IDLE (instruction leaves E this edge).
- hold=1 → stay in DONE.

flush=1 in any state:
- next state IDLE, no result produced;
- `ok` is forced to 1 that cycle.

resetn low mid-operation:
- immediate IDLE, `ok` follows ~valid, result 0;
- no partial result is ever observable.

## Timing
- `ok` low cycles, counting the accept cycle:
  - MUL* = 1 + 64/MUL_CHUNK (5 at default);
  - DIV/REM = 65;
  - DIVW/REMW = 33.
- result registered; valid from the first DONE cycle until DONE exits.
- Back-to-back M ops: DONE→IDLE on an edge; the next instruction in E is accepted in that same IDLE cycle (one ok=1 cycle between ops when hold=0).
- The operand latch happens only in IDLE. Changes on src_a/src_b during MUL/DIV/DONE are ignored; forwarding-path glitches while stalled are harmless.
- `hold` during MUL/DIV has no effect; it matters only in DONE.

## Configuration
- DIV_SPECIAL_FAST_EN defined:
  - divisor zero or signed overflow is detected in IDLE;
  - next state DONE directly with the finalized special-case result;
  - `ok` low for exactly 1 cycle.
- Undefined: special cases run the full 65/33-cycle iteration, then apply the same finalize overrides. Architectural results are identical.

## Test plan
- MUL a=−3, b=7, hold=0 → ok low 5 cycles, result 0xFFFF_FFFF_FFFF_FFEB, DONE one cycle, then IDLE.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MULHSU a=−1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=−7, b=2 → ok low 65 cycles, −3; REM same operands → −1. DIVUW a=0x1_0000_0010, b=4 → 4, ok low 33.
- DIV a=5, b=0 → −1; REM a=5, b=0 → 5. DIV 0x8000_0000_0000_0000 by −1 → 0x8000…0. With DIV_SPECIAL_FAST_EN ok low 1 cycle; without, 65.
- DONE with hold=1 for 3 cycles → result stable and ok=1 throughout; src changes ignored; IDLE on the first hold=0 edge.
- flush at DIV iteration 10 → IDLE next cycle, ok=1. resetn pulse mid-MUL → result 0, IDLE, a subsequent MUL still produces the correct result.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit - iterative RV64M multiply/divide unit for the execute stage.
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their *W
// forms over several cycles. 'ok' feeds the hazard unit as mult_ok. While it
// is low the front of the pipe is stalled. The result is held in DONE until
// the E-stage instruction advances (hold=0).
//
// Handshake: in IDLE, valid=1 starts an operation on the next edge and
// ok=~valid. In MUL/DIV, ok=0. In DONE, ok=1 and the result is valid. The
// instruction leaves E on the first DONE edge with hold=0. flush=1 forces
// ok=1 and sends the unit to IDLE without producing a result.
//
// Parameters: MUL_CHUNK - multiplier bits retired per MUL cycle. It must
//             divide 64 and be smaller than 64.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   valid, op, word   E-stage M instruction, funct3, *W variant
//   src_a, src_b      forwarded rs1 / rs2
//   hold, flush       E held for another reason / kill E instruction
//   ok, result        done-or-idle flag, registered result
//   dbg_state_o       current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
//
// Optional feature: define DIV_SPECIAL_FAST_EN to finish a divide by zero or
// a signed overflow in one cycle. This detection happens in IDLE.
module mul_div_unit #(
    parameter int MUL_CHUNK = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic        word,
    input  logic [63:0] src_a,
    input  logic [63:0] src_b,
    input  logic        hold,
    input  logic        flush,
    output logic        ok,
    output logic [63:0] result,
    output logic [1:0]  dbg_state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int MUL_ITERS = 64 / MUL_CHUNK;
    localparam int PW        = 64 + MUL_CHUNK;

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [63:0]  a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [127:0] acc_q, acc_d;
    logic         neg_q, neg_d, a_neg_q, a_neg_d;
    logic         dz_q, dz_d, ovf_q, ovf_d;
    logic [2:0]   op_q, op_d;
    logic         word_q, word_d;
    logic [63:0]  result_q, result_d;

    // Operand view in IDLE. Word ops see the low 32 bits, sign- or zero-extended.
    logic         a_signed, b_signed, a_sgn, b_sgn, in_dz, in_ovf;
    logic [63:0]  a_view, b_view, a_abs, b_abs, min_v;
    assign a_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign b_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    assign a_view   = word ? (a_signed ? {{32{src_a[31]}}, src_a[31:0]} : {32'b0, src_a[31:0]}) : src_a;
    assign b_view   = word ? (b_signed ? {{32{src_b[31]}}, src_b[31:0]} : {32'b0, src_b[31:0]}) : src_b;
    assign a_sgn    = a_signed & a_view[63];
    assign b_sgn    = b_signed & b_view[63];
    assign a_abs    = a_sgn ? -a_view : a_view;
    assign b_abs    = b_sgn ? -b_view : b_view;
    assign min_v    = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign in_dz    = (b_view == 64'b0);
    assign in_ovf   = op[2] & ~op[0] & (a_view == min_v) & (b_view == '1);

    // Multiply step. The chunk product is added into the upper half, then the
    // accumulator shifts right by MUL_CHUNK. The first partial product lands
    // at bit 0 after the final shift.
    logic [PW-1:0]  mul_sum;
    logic [127:0]   mul_raw;
    assign mul_sum = PW'(acc_q[127:64]) + PW'(a_mag_q) * PW'(b_mag_q[MUL_CHUNK-1:0]);
    assign mul_raw = {mul_sum, acc_q[63:MUL_CHUNK]};

    // Restoring divide step. acc holds {remainder, dividend/quotient}. The
    // shifted remainder may need 65 bits before the trial subtract.
    logic [64:0]  div_diff;
    logic [127:0] div_next;
    assign div_diff = acc_q[127:63] - {1'b0, b_mag_q};
    assign div_next = div_diff[64] ? {acc_q[126:0], 1'b0}
                                   : {div_diff[63:0], acc_q[62:0], 1'b1};

    function automatic logic [63:0] div_final(
        input logic [63:0] quo, input logic [63:0] rem, input logic [63:0] a_mag,
        input logic a_neg, input logic neg, input logic dz, input logic ovf,
        input logic is_rem, input logic is_word);
        logic [63:0] q, r, res;
        q = neg ? -quo : quo;
        r = a_neg ? -rem : rem;
        if (dz) begin
            q = '1;
            r = a_neg ? -a_mag : a_mag;
        end
        if (ovf) begin
            q = is_word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            r = 64'b0;
        end
        res = is_rem ? r : q;
        return is_word ? {{32{res[31]}}, res[31:0]} : res;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        op_d     = op_q;
        word_d   = word_q;
        result_d = result_q;
        ok       = 1'b1;
        case (state_q)
            S_IDLE: begin
                ok = ~valid;
                if (valid) begin
                    a_mag_d = a_abs;
                    b_mag_d = b_abs;
                    a_neg_d = a_sgn;
                    neg_d   = a_sgn ^ b_sgn;
                    dz_d    = op[2] & in_dz;
                    ovf_d   = in_ovf;
                    op_d    = op;
                    word_d  = word;
                    cnt_d   = 6'd0;
                    if (op[2]) begin
                        // Word dividends are left-aligned in the low half, so 32 steps suffice.
                        acc_d   = word ? {64'b0, a_abs[31:0], 32'b0} : {64'b0, a_abs};
                        state_d = S_DIV;
`ifdef DIV_SPECIAL_FAST_EN
                        if (in_dz || in_ovf) begin
                            state_d  = S_DONE;
                            result_d = div_final(64'b0, 64'b0, a_abs, a_sgn, a_sgn ^ b_sgn,
                                                 in_dz, in_ovf, op[1], word);
                        end
`endif
                    end else begin
                        acc_d   = 128'b0;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                ok      = 1'b0;
                acc_d   = mul_raw;
                b_mag_d = b_mag_q >> MUL_CHUNK;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(MUL_ITERS - 1)) begin
                    acc_d   = neg_q ? -mul_raw : mul_raw;
                    state_d = S_DONE;
                    if (op_q == 3'b000)
                        result_d = word_q ? {{32{acc_d[31]}}, acc_d[31:0]} : acc_d[63:0];
                    else
                        result_d = acc_d[127:64];
                end
            end
            S_DIV: begin
                ok    = 1'b0;
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == (word_q ? 6'd31 : 6'd63)) begin
                    state_d  = S_DONE;
                    result_d = div_final(div_next[63:0], div_next[127:64], a_mag_q, a_neg_q,
                                         neg_q, dz_q, ovf_q, op_q[1], word_q);
                end
            end
            default: begin
                ok = 1'b1;
                if (!hold) state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            ok       = 1'b1;
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            a_mag_q  <= 64'b0;
            b_mag_q  <= 64'b0;
            acc_q    <= 128'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            op_q     <= 3'b0;
            word_q   <= 1'b0;
            result_q <= 64'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            op_q     <= op_d;
            word_q   <= word_d;
            result_q <= result_d;
        end
    end

    assign result      = result_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int CHUNK = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src_a, src_b;
  logic        hold, flush;
  logic        ok;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.MUL_CHUNK(CHUNK)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .word(word),
    .src_a(src_a), .src_b(src_b), .hold(hold), .flush(flush),
    .ok(ok), .result(result), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: architectural RV64M result
  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [31:0]  t, q32, r32, ua, ub;
    logic [63:0]  q64, r64;
    int           wa, wb;
    longint       sa, sb;
    ua = a[31:0]; ub = b[31:0]; wa = a[31:0]; wb = b[31:0]; sa = a; sb = b;
    case (o)
      3'd0: begin
        if (w) begin t = a[31:0] * b[31:0]; return {{32{t[31]}}, t}; end
        return a * b;
      end
      3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
      3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'b0, b};       p = pa * pb; return p[127:64]; end
      3'd3: begin pa = {64'b0, a};       pb = {64'b0, b};       p = pa * pb; return p[127:64]; end
      default: begin
        if (w) begin
          if (ub == 0) begin q32 = '1; r32 = ua; end
          else if (!o[0] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin q32 = ua; r32 = 0; end
          else if (!o[0]) begin q32 = wa / wb; r32 = wa % wb; end
          else begin q32 = ua / ub; r32 = ua % ub; end
          t = o[1] ? r32 : q32;
          return {{32{t[31]}}, t};
        end
        if (b == 0) begin q64 = '1; r64 = a; end
        else if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = 0; end
        else if (!o[0]) begin q64 = sa / sb; r64 = sa % sb; end
        else begin q64 = a / b; r64 = a % b; end
        return o[1] ? r64 : q64;
      end
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic special;
    if (!o[2]) return 1 + 64 / CHUNK;
    special = w ? (b[31:0] == 0) : (b == 0);
    if (!o[0]) special = special | (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                                      : (a == 64'h8000_0000_0000_0000 && b == '1));
`ifdef DIV_SPECIAL_FAST_EN
    if (special) return 1;
`endif
    return w ? 33 : 65;
  endfunction

  // driver: presents one op at the current negedge, waits for ok, checks latency
  // and result, holds DONE for hold_n extra cycles, then confirms the return to
  // IDLE (valid still high, so ok=0). The caller either drives the next op
  // back to back or calls go_idle.
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold_n, input string name,
                        input logic [63:0] exp);
    int cyc, want;
    want = exp_cycles(o, w, a, b);
    valid = 1'b1; op = o; word = w; src_a = a; src_b = b; hold = (hold_n > 0);
    cyc = 0;
    #1;
    while (!ok && cyc < 300) begin
      cyc++;
      @(negedge clk);
      src_a = {$urandom, $urandom};
      src_b = {$urandom, $urandom};
      #1;
    end
    n_tests++;
    if (cyc !== want) begin
      n_fail++;
      $display("FAIL %s latency: got %0d ok-low cycles, expected %0d", name, cyc, want);
    end
    n_tests++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, result, exp);
    end
    for (int i = 0; i < hold_n; i++) begin
      src_a = {$urandom, $urandom};
      src_b = {$urandom, $urandom};
      @(negedge clk); #1;
      n_tests++;
      if (ok !== 1'b1 || result !== exp) begin
        n_fail++;
        $display("FAIL %s hold%0d: ok=%b result=%h expected ok=1 result=%h", name, i, ok, result, exp);
      end
    end
    hold = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_done: ok=%b expected 0", name, ok);
    end
  endtask

  task automatic go_idle();
    valid = 1'b0; hold = 1'b0; flush = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL go_idle: ok=%b expected 1", ok);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; op = 3'd0; word = 1'b0;
    src_a = 64'b0; src_b = 64'b0; hold = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (ok !== 1'b1 || result !== 64'b0) begin
      n_fail++;
      $display("FAIL reset_state: ok=%b result=%h expected ok=1 result=0", ok, result);
    end
    valid = 1'b1; #1;
    n_tests++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ok_follows_valid: ok=%b expected 0", ok);
    end
    valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
  endtask

  // directed multiplies, back to back
  task automatic test_mul();
    run_op(3'd0, 1'b0, -64'sd3, 64'd7, 0, "mul_neg3x7", 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd3, 1'b0, '1, '1, 0, "mulhu_max", 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd2, 1'b0, '1, 64'd2, 0, "mulhsu_m1x2", 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd0, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 0, "mulw_wrap", 64'h0000_0000_0000_0000);
    go_idle();
  endtask

  task automatic test_div();
    run_op(3'd4, 1'b0, -64'sd7, 64'd2, 0, "div_neg7_2", 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd6, 1'b0, -64'sd7, 64'd2, 0, "rem_neg7_2", 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd5, 1'b1, 64'h1_0000_0010, 64'd4, 0, "divuw", 64'd4);
    go_idle();
  endtask

  task automatic test_div_special();
    run_op(3'd4, 1'b0, 64'd5, 64'd0, 0, "div_by_zero", 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd6, 1'b0, 64'd5, 64'd0, 0, "rem_by_zero", 64'd5);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "div_overflow", 64'h8000_0000_0000_0000);
    run_op(3'd6, 1'b1, 64'h8000_0000, '1, 0, "remw_overflow", 64'd0);
    go_idle();
  endtask

  task automatic test_hold();
    run_op(3'd0, 1'b0, 64'd12345, 64'd6789, 3, "mul_hold3", model(3'd0, 1'b0, 64'd12345, 64'd6789));
    go_idle();
  endtask

  task automatic test_flush();
    valid = 1'b1; op = 3'd4; word = 1'b0; src_a = 64'd1000; src_b = 64'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1; #1;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ok: ok=%b expected 1", ok);
    end
    @(negedge clk);
    flush = 1'b0; valid = 1'b0; #1;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: ok=%b expected 1", ok);
    end
    run_op(3'd0, 1'b0, 64'd99, 64'd101, 0, "mul_after_flush", model(3'd0, 1'b0, 64'd99, 64'd101));
    go_idle();
  endtask

  task automatic test_reset_mid();
    valid = 1'b1; op = 3'd1; word = 1'b0; src_a = -64'sd5; src_b = 64'd9;
    repeat (3) @(negedge clk);
    resetn = 1'b0; #1;
    n_tests++;
    if (result !== 64'b0 || ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ok=%b result=%h expected ok=0 result=0", ok, result);
    end
    valid = 1'b0; #1;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ok: ok=%b expected 1", ok);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    run_op(3'd1, 1'b0, -64'sd5, 64'd9, 0, "mulh_after_reset", model(3'd1, 1'b0, -64'sd5, 64'd9));
    go_idle();
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  o;
    logic        w;
    logic [63:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      w = (o == 3'd0 || o[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = rand_operand();
      b = rand_operand();
      run_op(o, w, a, b, $urandom_range(0, 2), "random", model(o, w, a, b));
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
